// File: rtl/mem_arbiter.sv
// Two-client round-robin arbiter in front of a single-clock memory with
// separate write/read ports; optional lock keeps ownership for a bounded burst.
module mem_arbiter #(
  parameter int ADDR_W    = 6,
  parameter int DATA_W    = 10,
  parameter int BURST_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic              lock0,
  input  logic              lock1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_write,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_addr_w,
  output logic [ADDR_W-1:0] mem_addr_r,
  output logic [DATA_W-1:0] mem_datain,
  input  logic [DATA_W-1:0] mem_dataout
);

  localparam int CNT_W = $clog2(BURST_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_MAX);

  typedef enum logic {
    CLIENT0 = 1'b0,
    CLIENT1 = 1'b1
  } client_e;

  client_e           last_q;
  client_e           winner;
  logic [CNT_W-1:0]  cnt_q;
  logic              locked_q;
  logic              grant_any;
  logic              sel_we;
  logic              sel_lock;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  always_comb begin
    grant_any = 1'b0;
    winner    = last_q;
    if (rst_n) begin
      unique case ({req1, req0})
        2'b01: begin
          grant_any = 1'b1;
          winner    = CLIENT0;
        end
        2'b10: begin
          grant_any = 1'b1;
          winner    = CLIENT1;
        end
        2'b11: begin
          grant_any = 1'b1;
          // A locked owner keeps the memory until it has used its burst quota.
          if (locked_q && (cnt_q < CNT_MAX)) winner = last_q;
          else winner = (last_q == CLIENT0) ? CLIENT1 : CLIENT0;
        end
        default: grant_any = 1'b0;
      endcase
    end
  end

  always_comb begin
    sel_we    = (winner == CLIENT0) ? we0    : we1;
    sel_lock  = (winner == CLIENT0) ? lock0  : lock1;
    sel_addr  = (winner == CLIENT0) ? addr0  : addr1;
    sel_wdata = (winner == CLIENT0) ? wdata0 : wdata1;
  end

  assign gnt0 = grant_any && (winner == CLIENT0);
  assign gnt1 = grant_any && (winner == CLIENT1);

  assign mem_write  = grant_any && sel_we;
  assign mem_read   = grant_any && !sel_we;
  assign mem_addr_w = mem_write ? sel_addr  : '0;
  assign mem_datain = mem_write ? sel_wdata : '0;
  assign mem_addr_r = mem_read  ? sel_addr  : '0;

  assign rdata0 = mem_dataout;
  assign rdata1 = mem_dataout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q   <= CLIENT1;
      cnt_q    <= '0;
      locked_q <= 1'b0;
      rvalid0  <= 1'b0;
      rvalid1  <= 1'b0;
    end else begin
      rvalid0 <= mem_read && (winner == CLIENT0);
      rvalid1 <= mem_read && (winner == CLIENT1);
      if (grant_any) begin
        if (winner == last_q) begin
          if (cnt_q < CNT_MAX) cnt_q <= cnt_q + CNT_W'(1);
        end else begin
          cnt_q <= CNT_W'(1);
        end
        last_q   <= winner;
        locked_q <= sel_lock;
      end else begin
        cnt_q    <= '0;
        locked_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: grant/bus checks inline, read data checked
// by a scoreboard monitor against per-client expectation queues.
module tb_mem_arbiter;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 10;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req0 = 0, req1 = 0, we0 = 0, we1 = 0, lock0 = 0, lock1 = 0;
  logic [ADDR_W-1:0] addr0 = '0, addr1 = '0;
  logic [DATA_W-1:0] wdata0 = '0, wdata1 = '0;
  logic              gnt0, gnt1, rvalid0, rvalid1, mem_write, mem_read;
  logic [DATA_W-1:0] rdata0, rdata1, mem_datain;
  logic [DATA_W-1:0] mem_dataout = '0;
  logic [ADDR_W-1:0] mem_addr_w, mem_addr_r;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] mem    [2**ADDR_W];
  logic [DATA_W-1:0] shadow [2**ADDR_W];
  logic [DATA_W-1:0] q0[$];
  logic [DATA_W-1:0] q1[$];

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .lock0(lock0), .lock1(lock1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_write(mem_write), .mem_read(mem_read),
    .mem_addr_w(mem_addr_w), .mem_addr_r(mem_addr_r),
    .mem_datain(mem_datain), .mem_dataout(mem_dataout)
  );

  always #5 clk = ~clk;

  // Memory model: registered read, read-before-write on collision.
  always @(posedge clk) begin
    if (mem_read) mem_dataout <= mem[mem_addr_r];
    if (mem_write) mem[mem_addr_w] <= mem_datain;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops an expectation whenever a client presents rvalid.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rvalid0 || q0.size() != 0) begin
        chk("rvalid0", rvalid0, q0.size() != 0);
        if (rvalid0 && q0.size() != 0) chk("rdata0", rdata0, q0.pop_front());
      end
      if (rvalid1 || q1.size() != 0) begin
        chk("rvalid1", rvalid1, q1.size() != 0);
        if (rvalid1 && q1.size() != 0) chk("rdata1", rdata1, q1.pop_front());
      end
    end
  end

  // One cycle with current inputs: check grant and memory drive, then queue
  // any read expectation so the monitor sees it on the following cycle.
  task automatic step(input bit e0, input bit e1);
    bit ew, er, p0, p1;
    logic [DATA_W-1:0] d0, d1;
    @(negedge clk);
    chk("gnt0", gnt0, e0);
    chk("gnt1", gnt1, e1);
    ew = (e0 && we0) || (e1 && we1);
    er = (e0 && !we0) || (e1 && !we1);
    chk("mem_write", mem_write, ew);
    chk("mem_read", mem_read, er);
    if (ew) begin
      chk("mem_addr_w", mem_addr_w, e0 ? addr0 : addr1);
      chk("mem_datain", mem_datain, e0 ? wdata0 : wdata1);
    end
    if (er) chk("mem_addr_r", mem_addr_r, e0 ? addr0 : addr1);
    if (!e0 && !e1) begin
      chk("idle_addr_w", mem_addr_w, 0);
      chk("idle_addr_r", mem_addr_r, 0);
    end
    p0 = e0 && !we0;
    p1 = e1 && !we1;
    d0 = shadow[addr0];
    d1 = shadow[addr1];
    if (e0 && we0) shadow[addr0] = wdata0;
    if (e1 && we1) shadow[addr1] = wdata1;
    @(posedge clk);
    #1;
    if (p0) q0.push_back(d0);
    if (p1) q1.push_back(d1);
  endtask

  task automatic idle_inputs();
    req0 = 0; req1 = 0; lock0 = 0; lock1 = 0; we0 = 0; we1 = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  initial begin
    bit exp5 [6] = '{1, 1, 1, 1, 0, 1};
    int k;
    for (int i = 0; i < 2**ADDR_W; i++) begin
      mem[i] = '0;
      shadow[i] = '0;
    end

    // Reset holds everything quiet even with a request pending.
    req0 = 1; we0 = 1; addr0 = 0; wdata0 = 12;
    @(negedge clk);
    chk("rst_gnt0", gnt0, 0);
    chk("rst_gnt1", gnt1, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_read", mem_read, 0);
    chk("rst_rvalid0", rvalid0, 0);
    chk("rst_rvalid1", rvalid1, 0);
    @(posedge clk);
    #1;
    rst_n = 1;
    step(1, 0);

    // Write then immediate read of same address from the other client.
    addr0 = 1; wdata0 = 13;
    step(1, 0);
    req0 = 0; req1 = 1; we1 = 0; addr1 = 1;
    step(0, 1);
    idle_inputs();
    step(0, 0);

    // Plain round-robin with both clients reading.
    do_reset();
    req0 = 1; we0 = 0; addr0 = 0;
    req1 = 1; we1 = 0; addr1 = 1;
    step(1, 0);
    step(0, 1);
    step(1, 0);
    step(0, 1);
    idle_inputs();
    step(0, 0);

    // Locked burst: client 0 writes, client 1 reads the word just written.
    k = 0;
    req0 = 1; we0 = 1; lock0 = 1; addr0 = 2; wdata0 = 10'(100);
    req1 = 1; we1 = 0; addr1 = 2;
    for (int i = 0; i < 6; i++) begin
      step(exp5[i], !exp5[i]);
      if (exp5[i]) begin
        k++;
        wdata0 = 10'(100 + k);
      end else begin
        req1 = 0;
      end
    end
    idle_inputs();
    step(0, 0);

    // Lone locked requester: never rotates; saturated count then yields.
    req0 = 1; we0 = 0; lock0 = 1; addr0 = 2;
    for (int i = 0; i < 10; i++) step(1, 0);
    req1 = 1; we1 = 0; addr1 = 0;
    step(0, 1);
    req1 = 0;
    step(1, 0);
    idle_inputs();
    step(0, 0);

    // Reset during the rvalid cycle discards the read result.
    req0 = 1; we0 = 0; addr0 = 1;
    @(negedge clk);
    chk("rst_mid_gnt0", gnt0, 1);
    @(posedge clk);
    #1;
    rst_n = 0;
    req0 = 0;
    @(negedge clk);
    chk("rst_mid_rvalid0", rvalid0, 0);
    chk("rst_mid_mem_read", mem_read, 0);
    @(posedge clk);
    #1;
    rst_n = 1;
    step(0, 0);
    step(0, 0);

    // Data written before the reset is still there.
    req1 = 1; we1 = 0; addr1 = 2;
    step(0, 1);
    idle_inputs();
    step(0, 0);
    step(0, 0);

    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout actual %0t required finish", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester round-robin arbiter that shares one single-clock memory (separate write/read ports, 1-cycle registered read, read-before-write on same-address collision) between two clients. Sits directly in front of the memory instance; each client issues single read or write operations with a req/gnt handshake and receives read data tagged by its own `rvalid`. An optional lock lets a client hold the memory for a bounded burst.

## Interface
- `ADDR_W`, 6, memory address width (memory depth 2**ADDR_W).
- `DATA_W`, 10, data word width.
- `BURST_MAX`, 4, maximum consecutive grants a locking client keeps while the other client waits; ≥1 (1 disables lock effect).

- `clk`  in  1  single clock, all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req0`/`req1`  in  1  client requests one memory operation; held until `gnt`.
- `we0`/`we1`  in  1  1 = write, 0 = read; stable while `req` high.
- `lock0`/`lock1`  in  1  request to keep ownership on the next cycle.
- `addr0`/`addr1`  in  ADDR_W  operation address.
- `wdata0`/`wdata1`  in  DATA_W  write data.
- `gnt0`/`gnt1`  out  1  combinational grant; operation accepted this cycle.
- `rvalid0`/`rvalid1`  out  1  registered; read data for that client valid this cycle.
- `rdata0`/`rdata1`  out  DATA_W  both driven from `mem_dataout`; meaningful only with `rvalid`.
- `mem_write`  out  1  memory write enable.
- `mem_read`  out  1  memory read enable.
- `mem_addr_w`/`mem_addr_r`  out  ADDR_W  memory write/read address.
- `mem_datain`  out  DATA_W  memory write data.
- `mem_dataout`  in  DATA_W  memory registered read data.

## Operation
- State: `last` (1 bit, last granted client), `cnt` (clog2(BURST_MAX+1) bits, consecutive grants to `last`, saturating at BURST_MAX), `locked` (lock value of last grant), `rvalid0/1`.
- Reset values: `last`=1 (client 0 wins first tie), `cnt`=0, `locked`=0, `rvalid0/1`=0. While `rst_n`=0: `gnt0/1`=0, `mem_write`=`mem_read`=0.
- Grant decision (combinational, per cycle):
  - no req: no grant.
  - one req: that client granted, regardless of lock/cnt.
  - both req: if `locked`=1 and `cnt`<BURST_MAX, grant `last`; otherwise grant the client ≠ `last`.
- At most one grant per cycle; gnt0 & gnt1 never both high.
- Memory drive: granted client with `we`=1 → `mem_write`=1, `mem_addr_w`=addr, `mem_datain`=wdata, `mem_read`=0; `we`=0 → `mem_read`=1, `mem_addr_r`=addr, `mem_write`=0. No grant → both enables 0, address/data buses 0.
- Update on grant to client W: W==`last` → `cnt`<=min(cnt+1, BURST_MAX), else `cnt`<=1; `last`<=W; `locked`<=lockW.
- Update with no grant: `cnt`<=0, `locked`<=0, `last` unchanged.
- `rvalidW`<=1 for the cycle after a read grant to W; 0 otherwise. Writes never produce `rvalid`.

## Timing
- Cycle T: req high, gnt high same cycle (zero-latency grant); memory samples command at rising edge ending T.
- Read: `rvalid`/`rdata` valid in cycle T+1 (1-cycle latency). Back-to-back reads every cycle allowed, one result per cycle, in order.
- Write at T then read of same address at T+1 returns new data at T+2.
- Memory does not see read/write on same cycle from this block; no same-cycle collision.
- Loser keeps req high; served at latest after BURST_MAX grants to the other client (fairness bound).
- Async reset mid-operation: `rvalid` cleared immediately, outstanding read result discarded; client must re-request. Writes completed at prior edges remain in memory.

## Test plan
- Reset, both req=0 → all gnt/rvalid=0, mem_write=mem_read=0; release, req0 write addr 0 data 12 → gnt0 same cycle, mem_write=1, mem_addr_w=0, mem_datain=12.
- Client 0 writes 13 to addr 1, next cycle client 1 reads addr 1 → gnt1, rvalid1=1 one cycle later with rdata1=13, rvalid0 stays 0.
- Both req continuously, lock=0, reads → grants alternate 0,1,0,1; first grant to client 0 after reset.
- Both req, lock0=1 held, BURST_MAX=4 → gnt0 for 4 consecutive cycles, then gnt1 once, then client 0 again.
- Single requester with lock0=1 for 10 cycles → gnt0 every cycle, cnt saturates at 4, no rotation.
- Read grant at T, rst_n low during T+1 → rvalid0=0 immediately; after release no stale rvalid.
